inst_fetch_sched: RTL

Synchronous instruction sequencer for the TPU instruction stream. On `start` it fetches 128-bit instructions from BRAM at consecutive addresses and decodes opcode [127:120]. Each instruction goes to one of five handler channels (SEND_INST, SEND_DATA, GET_DATA, FREE, GET_STATUS) over a valid/ready/done handshake. The block waits for completion before fetching the next instruction, and stops on an END opcode, an illegal opcode or an instruction limit.

---
 rtl/inst_fetch_sched_pkg.sv | 25 ++
 rtl/inst_fetch_sched_if.sv | 23 ++
 rtl/inst_fetch_sched_opdecode.sv | 27 ++
 rtl/inst_fetch_sched.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_sched_pkg.sv
// rtl/inst_fetch_sched_pkg.sv - shared opcodes, channel count and FSM state type for the instruction sequencer
package inst_sched_pkg;

    localparam int NUM_CH = 5;

    localparam logic [7:0] OP_SEND_INST  = 8'h10;
    localparam logic [7:0] OP_SEND_DATA  = 8'h11;
    localparam logic [7:0] OP_GET_DATA   = 8'h12;
    localparam logic [7:0] OP_FREE       = 8'h13;
    localparam logic [7:0] OP_GET_STATUS = 8'h14;
    localparam logic [7:0] OP_END        = 8'h1F;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RD,
        DECODE,
        DISPATCH,
        EXEC,
        DONE
    } state_t;

    typedef logic [2:0] ch_idx_t;

endpackage

// File: rtl/inst_fetch_sched_if.sv
// rtl/inst_fetch_sched_if.sv - BRAM read port and handler dispatch bundle
interface inst_fetch_sched_if;
    import inst_sched_pkg::*;

    logic              RD_START;
    logic [31:0]       RD_ADDR;
    logic [127:0]      RD_DATA;
    logic              RD_DONE;
    logic [NUM_CH-1:0] disp_valid;
    logic [127:0]      disp_inst;
    logic [NUM_CH-1:0] disp_ready;
    logic [NUM_CH-1:0] disp_done;

    modport master (
        output RD_START, RD_ADDR, disp_valid, disp_inst,
        input  RD_DATA, RD_DONE, disp_ready, disp_done
    );

    modport slave (
        input  RD_START, RD_ADDR, disp_valid, disp_inst,
        output RD_DATA, RD_DONE, disp_ready, disp_done
    );
endinterface

// File: rtl/inst_fetch_sched_opdecode.sv
// rtl/inst_fetch_sched_opdecode.sv - combinational opcode to channel/end/illegal classifier
module inst_opdecode
    import inst_sched_pkg::*;
(
    input  logic [7:0]        op,
    output logic [NUM_CH-1:0] ch_onehot,
    output logic              is_end,
    output logic              is_illegal
);

    // Exactly one of ch_onehot, is_end, is_illegal is active for any opcode
    always_comb begin
        ch_onehot  = '0;
        is_end     = 1'b0;
        is_illegal = 1'b0;
        case (op)
            OP_SEND_INST:  ch_onehot = 5'b00001;
            OP_SEND_DATA:  ch_onehot = 5'b00010;
            OP_GET_DATA:   ch_onehot = 5'b00100;
            OP_FREE:       ch_onehot = 5'b01000;
            OP_GET_STATUS: ch_onehot = 5'b10000;
            OP_END:        is_end    = 1'b1;
            default:       is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_fetch_sched.sv
// rtl/inst_fetch_sched.sv - instruction fetch/decode/dispatch sequencer; INST_FETCH_PREFETCH_EN adds a one-entry prefetch
module inst_fetch_sched
    import inst_sched_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
    parameter int unsigned ADDR_STEP = 16,
    parameter int unsigned MAX_INST  = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               finish,
    output logic               err,
    output logic [15:0]        inst_count,
    inst_fetch_sched_if.master bus
);

    localparam logic [31:0] STEP32 = 32'(ADDR_STEP);
    localparam logic [15:0] MAX16  = 16'(MAX_INST);

    state_t            state_q, state_d;
    logic [31:0]       ptr_q, ptr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [127:0]      inst_q, inst_d;
    logic [NUM_CH-1:0] ch_q, ch_d;
    logic              busy_q, busy_d;
    logic              finish_q, finish_d;
    logic              err_q, err_d;
    logic              rd_start_q, rd_start_d;
    logic [31:0]       rd_addr_q, rd_addr_d;
    logic [NUM_CH-1:0] disp_valid_q, disp_valid_d;
    logic [127:0]      disp_inst_q, disp_inst_d;

`ifdef INST_FETCH_PREFETCH_EN
    logic [127:0]      pf_buf_q, pf_buf_d;
    logic              pf_vld_q, pf_vld_d;
    logic              pf_pend_q, pf_pend_d;
`endif

    logic [NUM_CH-1:0] dec_oh;
    logic              dec_end;
    logic              dec_ill;
    logic              hs_hit;
    logic              done_hit;
    logic [15:0]       cnt_inc;
    logic [31:0]       ptr_inc;

    inst_opdecode u_dec (
        .op         (inst_q[127:120]),
        .ch_onehot  (dec_oh),
        .is_end     (dec_end),
        .is_illegal (dec_ill)
    );

    // Only the selected channel's ready/done matter; other channels are masked off
    assign hs_hit   = |(bus.disp_ready & disp_valid_q);
    assign done_hit = |(bus.disp_done & ch_q);
    assign cnt_inc  = cnt_q + 16'd1;
    assign ptr_inc  = ptr_q + STEP32;

    // Next-state and next-output computation for the sequencer FSM
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        inst_d       = inst_q;
        ch_d         = ch_q;
        busy_d       = busy_q;
        finish_d     = 1'b0;
        err_d        = err_q;
        rd_start_d   = rd_start_q;
        rd_addr_d    = rd_addr_q;
        disp_valid_d = disp_valid_q;
        disp_inst_d  = disp_inst_q;
`ifdef INST_FETCH_PREFETCH_EN
        pf_buf_d     = pf_buf_q;
        pf_vld_d     = pf_vld_q;
        pf_pend_d    = pf_pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = BASE_ADDR;
                    cnt_d   = 16'd0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (cnt_q == MAX16) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    rd_start_d = 1'b1;
                    rd_addr_d  = ptr_q;
                    state_d    = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (bus.RD_DONE) begin
                    inst_d     = bus.RD_DATA;
                    rd_start_d = 1'b0;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                if (dec_end) begin
                    state_d = DONE;
                end else if (dec_ill) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    ch_d         = dec_oh;
                    disp_valid_d = dec_oh;
                    disp_inst_d  = inst_q;
                    state_d      = DISPATCH;
                end
            end
            DISPATCH: begin
                if (hs_hit) begin
                    disp_valid_d = '0;
                    cnt_d        = cnt_inc;
                    ptr_d        = ptr_inc;
                    if (done_hit) begin
                        state_d = FETCH;
                    end else begin
                        state_d = EXEC;
`ifdef INST_FETCH_PREFETCH_EN
                        // Overlap the next read with handler execution
                        if (cnt_inc < MAX16) begin
                            rd_start_d = 1'b1;
                            rd_addr_d  = ptr_inc;
                            pf_pend_d  = 1'b1;
                        end
`endif
                    end
                end
            end
            EXEC: begin
`ifdef INST_FETCH_PREFETCH_EN
                if (pf_pend_q && bus.RD_DONE) begin
                    pf_buf_d   = bus.RD_DATA;
                    pf_vld_d   = 1'b1;
                    pf_pend_d  = 1'b0;
                    rd_start_d = 1'b0;
                end
                if (done_hit) begin
                    if (pf_vld_q) begin
                        inst_d   = pf_buf_q;
                        pf_vld_d = 1'b0;
                        state_d  = DECODE;
                    end else if (pf_pend_q && bus.RD_DONE) begin
                        inst_d   = bus.RD_DATA;
                        pf_vld_d = 1'b0;
                        state_d  = DECODE;
                    end else if (pf_pend_q) begin
                        // Read still in flight: WAIT_RD finishes it with RD_START held high
                        pf_pend_d = 1'b0;
                        state_d   = WAIT_RD;
                    end else begin
                        state_d = FETCH;
                    end
                end
`else
                if (done_hit) begin
                    state_d = FETCH;
                end
`endif
            end
            DONE: begin
                finish_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
`ifdef INST_FETCH_PREFETCH_EN
                pf_buf_d  = '0;
                pf_vld_d  = 1'b0;
                pf_pend_d = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any run without a finish pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            inst_q       <= '0;
            ch_q         <= '0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
            err_q        <= 1'b0;
            rd_start_q   <= 1'b0;
            rd_addr_q    <= '0;
            disp_valid_q <= '0;
            disp_inst_q  <= '0;
`ifdef INST_FETCH_PREFETCH_EN
            pf_buf_q     <= '0;
            pf_vld_q     <= 1'b0;
            pf_pend_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            inst_q       <= inst_d;
            ch_q         <= ch_d;
            busy_q       <= busy_d;
            finish_q     <= finish_d;
            err_q        <= err_d;
            rd_start_q   <= rd_start_d;
            rd_addr_q    <= rd_addr_d;
            disp_valid_q <= disp_valid_d;
            disp_inst_q  <= disp_inst_d;
`ifdef INST_FETCH_PREFETCH_EN
            pf_buf_q     <= pf_buf_d;
            pf_vld_q     <= pf_vld_d;
            pf_pend_q    <= pf_pend_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign finish         = finish_q;
    assign err            = err_q;
    assign inst_count     = cnt_q;
    assign bus.RD_START   = rd_start_q;
    assign bus.RD_ADDR    = rd_addr_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.disp_inst  = disp_inst_q;

endmodule
